// File: rtl/axi_rd_4_merger.sv
// 4-to-1 AXI read merger: round-robin AR arbitration into one registered stage, R beats routed back in AR order.
// Optional macro AXI_MERGER_LEN_CHECK_EN adds per-burst beat counting, forced rlast and a sticky rerr flag.
module axi_rd_4_merger #(
    parameter int unsigned EXTRAS = 8,
    parameter int unsigned IDWID  = 4,
    parameter int unsigned DWID   = 64,
    parameter int unsigned RDEPTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDWID-1:0]  a_arid,
    input  logic [31:0]       a_araddr,
    input  logic [7:0]        a_arlen,
    input  logic [EXTRAS-1:0] a_arextras,
    input  logic [1:0]        a_arburst,
    input  logic              a_arvalid,
    output logic              a_arready,
    output logic [IDWID-1:0]  a_rid,
    output logic [DWID-1:0]   a_rdata,
    output logic [1:0]        a_rresp,
    output logic              a_rlast,
    output logic              a_rvalid,
    input  logic              a_rready,
    input  logic [IDWID-1:0]  b_arid,
    input  logic [31:0]       b_araddr,
    input  logic [7:0]        b_arlen,
    input  logic [EXTRAS-1:0] b_arextras,
    input  logic [1:0]        b_arburst,
    input  logic              b_arvalid,
    output logic              b_arready,
    output logic [IDWID-1:0]  b_rid,
    output logic [DWID-1:0]   b_rdata,
    output logic [1:0]        b_rresp,
    output logic              b_rlast,
    output logic              b_rvalid,
    input  logic              b_rready,
    input  logic [IDWID-1:0]  c_arid,
    input  logic [31:0]       c_araddr,
    input  logic [7:0]        c_arlen,
    input  logic [EXTRAS-1:0] c_arextras,
    input  logic [1:0]        c_arburst,
    input  logic              c_arvalid,
    output logic              c_arready,
    output logic [IDWID-1:0]  c_rid,
    output logic [DWID-1:0]   c_rdata,
    output logic [1:0]        c_rresp,
    output logic              c_rlast,
    output logic              c_rvalid,
    input  logic              c_rready,
    input  logic [IDWID-1:0]  d_arid,
    input  logic [31:0]       d_araddr,
    input  logic [7:0]        d_arlen,
    input  logic [EXTRAS-1:0] d_arextras,
    input  logic [1:0]        d_arburst,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [IDWID-1:0]  d_rid,
    output logic [DWID-1:0]   d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [IDWID-1:0]  arid,
    output logic [31:0]       araddr,
    output logic [7:0]        arlen,
    output logic [EXTRAS-1:0] arextras,
    output logic [1:0]        arburst,
    output logic              arvalid,
    input  logic              arready,
    input  logic [IDWID-1:0]  rid,
    input  logic [DWID-1:0]   rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    output logic              rerr
);
    localparam int unsigned PW = $clog2(RDEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [IDWID-1:0]  id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [EXTRAS-1:0] extras;
        logic [1:0]        burst;
    } ar_t;

    ar_t        m_ar [4];
    logic [3:0] m_arvalid, m_arready, m_rready, m_rvalid;

    assign m_ar[0] = '{id: a_arid, addr: a_araddr, len: a_arlen, extras: a_arextras, burst: a_arburst};
    assign m_ar[1] = '{id: b_arid, addr: b_araddr, len: b_arlen, extras: b_arextras, burst: b_arburst};
    assign m_ar[2] = '{id: c_arid, addr: c_araddr, len: c_arlen, extras: c_arextras, burst: c_arburst};
    assign m_ar[3] = '{id: d_arid, addr: d_araddr, len: d_arlen, extras: d_arextras, burst: d_arburst};
    assign m_arvalid = {d_arvalid, c_arvalid, b_arvalid, a_arvalid};
    assign m_rready  = {d_rready, c_rready, b_rready, a_rready};
    assign {d_arready, c_arready, b_arready, a_arready} = m_arready;
    assign {d_rvalid, c_rvalid, b_rvalid, a_rvalid}     = m_rvalid;

    logic          arvalid_q;
    ar_t           ar_q;
    logic [1:0]    rr_ptr_q, cand, grant_idx;
    logic          grant_vld;
    logic [1:0]    route_src_q [RDEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          fifo_empty, fifo_full, load_ok, push, pop, beat, rlast_m;
    logic [1:0]    head;

    // Round-robin search starting at rr_ptr_q (one past the last winner).
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        cand      = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!grant_vld && m_arvalid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(RDEPTH));
    assign head       = route_src_q[rd_ptr_q];
    assign rready     = !fifo_empty && m_rready[head];
    assign beat       = rvalid && rready;
    assign pop        = beat && rlast_m;
    // A retiring burst frees its slot in the same cycle, so a full FIFO can still accept.
    assign load_ok    = (!arvalid_q || arready) && (!fifo_full || pop);
    assign push       = load_ok && grant_vld;
    assign m_arready  = push ? (4'(1) << grant_idx) : 4'b0;
    assign m_rvalid   = (!fifo_empty && rvalid) ? (4'(1) << head) : 4'b0;

    assign arvalid  = arvalid_q;
    assign arid     = ar_q.id;
    assign araddr   = ar_q.addr;
    assign arlen    = ar_q.len;
    assign arextras = ar_q.extras;
    assign arburst  = ar_q.burst;

    assign {a_rid, b_rid, c_rid, d_rid}         = {4{rid}};
    assign {a_rdata, b_rdata, c_rdata, d_rdata} = {4{rdata}};
    assign {a_rresp, b_rresp, c_rresp, d_rresp} = {4{rresp}};
    assign {a_rlast, b_rlast, c_rlast, d_rlast} = {4{rlast_m}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arvalid_q <= 1'b0;
            ar_q      <= '0;
            rr_ptr_q  <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < RDEPTH; i++) route_src_q[i] <= 2'd0;
        end else begin
            if (load_ok) begin
                arvalid_q <= grant_vld;
                if (grant_vld) begin
                    ar_q     <= m_ar[grant_idx];
                    rr_ptr_q <= grant_idx + 2'd1;
                end
            end
            if (push) begin
                route_src_q[wr_ptr_q] <= grant_idx;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push && !pop)      cnt_q <= cnt_q + CW'(1);
            else if (pop && !push) cnt_q <= cnt_q - CW'(1);
        end
    end

`ifdef AXI_MERGER_LEN_CHECK_EN
    logic [7:0] route_len_q [RDEPTH];
    logic [7:0] beat_cnt_q;
    logic       rerr_q, at_len;

    assign at_len  = (beat_cnt_q == route_len_q[rd_ptr_q]);
    assign rlast_m = rlast || at_len;
    assign rerr    = rerr_q;

    // Beat counting per head burst; any disagreement with slave rlast latches rerr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 8'd0;
            rerr_q     <= 1'b0;
            for (int i = 0; i < RDEPTH; i++) route_len_q[i] <= 8'd0;
        end else begin
            if (push) route_len_q[wr_ptr_q] <= m_ar[grant_idx].len;
            if (pop)       beat_cnt_q <= 8'd0;
            else if (beat) beat_cnt_q <= beat_cnt_q + 8'd1;
            if (beat && (rlast != at_len)) rerr_q <= 1'b1;
        end
    end
`else
    assign rlast_m = rlast;
    assign rerr    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_4_merger.sv
// Directed bench for axi_rd_4_merger: queue-based reference model checked every cycle plus hand-computed literals.
module tb_axi_rd_4_merger;
    localparam int unsigned EXTRAS = 8;
    localparam int unsigned IDWID  = 4;
    localparam int unsigned DWID   = 64;
    localparam int unsigned RDEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]        in_arvalid, in_rready;
    logic [IDWID-1:0]  in_arid     [4];
    logic [31:0]       in_araddr   [4];
    logic [7:0]        in_arlen    [4];
    logic [EXTRAS-1:0] in_arextras [4];
    logic [1:0]        in_arburst  [4];
    wire  [3:0]        o_arready, o_rvalid, o_rlast;
    wire  [IDWID-1:0]  o_rid   [4];
    wire  [DWID-1:0]   o_rdata [4];
    wire  [1:0]        o_rresp [4];
    wire  [IDWID-1:0]  arid;
    wire  [31:0]       araddr;
    wire  [7:0]        arlen;
    wire  [EXTRAS-1:0] arextras;
    wire  [1:0]        arburst;
    wire               arvalid, rready, rerr;
    logic              s_arready, s_rlast, s_rvalid;
    logic [IDWID-1:0]  s_rid;
    logic [DWID-1:0]   s_rdata;
    logic [1:0]        s_rresp;

    axi_rd_4_merger #(.EXTRAS(EXTRAS), .IDWID(IDWID), .DWID(DWID), .RDEPTH(RDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_arid(in_arid[0]), .a_araddr(in_araddr[0]), .a_arlen(in_arlen[0]), .a_arextras(in_arextras[0]),
        .a_arburst(in_arburst[0]), .a_arvalid(in_arvalid[0]), .a_arready(o_arready[0]),
        .a_rid(o_rid[0]), .a_rdata(o_rdata[0]), .a_rresp(o_rresp[0]), .a_rlast(o_rlast[0]),
        .a_rvalid(o_rvalid[0]), .a_rready(in_rready[0]),
        .b_arid(in_arid[1]), .b_araddr(in_araddr[1]), .b_arlen(in_arlen[1]), .b_arextras(in_arextras[1]),
        .b_arburst(in_arburst[1]), .b_arvalid(in_arvalid[1]), .b_arready(o_arready[1]),
        .b_rid(o_rid[1]), .b_rdata(o_rdata[1]), .b_rresp(o_rresp[1]), .b_rlast(o_rlast[1]),
        .b_rvalid(o_rvalid[1]), .b_rready(in_rready[1]),
        .c_arid(in_arid[2]), .c_araddr(in_araddr[2]), .c_arlen(in_arlen[2]), .c_arextras(in_arextras[2]),
        .c_arburst(in_arburst[2]), .c_arvalid(in_arvalid[2]), .c_arready(o_arready[2]),
        .c_rid(o_rid[2]), .c_rdata(o_rdata[2]), .c_rresp(o_rresp[2]), .c_rlast(o_rlast[2]),
        .c_rvalid(o_rvalid[2]), .c_rready(in_rready[2]),
        .d_arid(in_arid[3]), .d_araddr(in_araddr[3]), .d_arlen(in_arlen[3]), .d_arextras(in_arextras[3]),
        .d_arburst(in_arburst[3]), .d_arvalid(in_arvalid[3]), .d_arready(o_arready[3]),
        .d_rid(o_rid[3]), .d_rdata(o_rdata[3]), .d_rresp(o_rresp[3]), .d_rlast(o_rlast[3]),
        .d_rvalid(o_rvalid[3]), .d_rready(in_rready[3]),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arextras(arextras), .arburst(arburst),
        .arvalid(arvalid), .arready(s_arready),
        .rid(s_rid), .rdata(s_rdata), .rresp(s_rresp), .rlast(s_rlast), .rvalid(s_rvalid),
        .rready(rready), .rerr(rerr)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: pending AR slot, queue of outstanding bursts in issue order.
    int         m_ptr;
    bit         m_stv;
    logic [53:0] m_ar;
    int         m_route [$];
    int         m_rlen  [$];
    int         m_beat;
    bit         m_rerr;

    function automatic int winner();
        for (int i = 0; i < 4; i++) begin
            int j = (m_ptr + i) % 4;
            if (in_arvalid[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit at_len();
        return (m_route.size() > 0) && (m_beat == m_rlen[0]);
    endfunction

    function automatic bit exp_rlast();
`ifdef AXI_MERGER_LEN_CHECK_EN
        return s_rlast || at_len();
`else
        return s_rlast;
`endif
    endfunction

    function automatic bit beat();
        return (m_route.size() > 0) && s_rvalid && in_rready[m_route[0]];
    endfunction

    function automatic bit can_load();
        bit retire = beat() && exp_rlast();
        return (!m_stv || s_arready) && ((m_route.size() < RDEPTH) || retire);
    endfunction

    function automatic logic [3:0] exp_arready();
        int w = winner();
        if (can_load() && w >= 0) return 4'(1 << w);
        return 4'b0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr = 0; m_stv = 0; m_ar = '0; m_beat = 0; m_rerr = 0;
            m_route.delete(); m_rlen.delete();
        end else begin
            int w;
            bit ld, bt, pp;
            w  = winner();
            ld = can_load();
            bt = beat();
            pp = bt && exp_rlast();
`ifdef AXI_MERGER_LEN_CHECK_EN
            if (bt && (s_rlast != at_len())) m_rerr = 1;
`endif
            if (bt) m_beat = pp ? 0 : m_beat + 1;
            if (pp) begin
                void'(m_route.pop_front());
                void'(m_rlen.pop_front());
            end
            if (ld) begin
                if (w >= 0) begin
                    m_route.push_back(w);
                    m_rlen.push_back(int'(in_arlen[w]));
                    m_ar  = {in_arid[w], in_araddr[w], in_arlen[w], in_arextras[w], in_arburst[w]};
                    m_stv = 1;
                    m_ptr = (w + 1) % 4;
                end else begin
                    m_stv = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, mid-cycle after inputs have settled.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            logic [3:0] ev;
            int hd;
            hd = (m_route.size() > 0) ? m_route[0] : -1;
            ev = (hd >= 0 && s_rvalid) ? 4'(1 << hd) : 4'b0;
            chk("arready", 64'(o_arready), 64'(exp_arready()));
            chk("arvalid", 64'(arvalid), 64'(m_stv));
            if (m_stv) chk("ar_fields", 64'({arid, araddr, arlen, arextras, arburst}), 64'(m_ar));
            chk("rvalid", 64'(o_rvalid), 64'(ev));
            chk("rready", 64'(rready), 64'((hd >= 0) && in_rready[hd]));
`ifdef AXI_MERGER_LEN_CHECK_EN
            chk("rerr", 64'(rerr), 64'(m_rerr));
`else
            chk("rerr", 64'(rerr), 64'(0));
`endif
            if (ev != 4'b0) begin
                chk("r_side", 64'({o_rid[hd], o_rresp[hd], o_rlast[hd]}), 64'({s_rid, s_rresp, exp_rlast()}));
                chk("r_data", 64'(o_rdata[hd]), 64'(s_rdata));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        in_arvalid = 4'b0; in_rready = 4'hF;
        s_arready = 1'b1; s_rvalid = 1'b0; s_rlast = 1'b0;
        s_rdata = '0; s_rid = '0; s_rresp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            in_arid[i]     = IDWID'(i + 1);
            in_araddr[i]   = 32'h1000 * 32'(i + 1);
            in_arlen[i]    = 8'd0;
            in_arextras[i] = EXTRAS'(8'h10 + 8'(i));
            in_arburst[i]  = 2'b01;
        end
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic drive_beat(input logic [DWID-1:0] d, input bit last);
        s_rvalid = 1'b1; s_rdata = d; s_rlast = last;
        s_rid = IDWID'(d[3:0]); s_rresp = 2'(d[1:0]);
    endtask

    initial begin
        logic [3:0] ord [6];
        int         ids [6];
        logic [3:0] t3v [3];
        bit         t3l [3];
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        ids = '{1, 2, 3, 4, 1, 2};
        t3v = '{4'b0100, 4'b0100, 4'b0001};
        t3l = '{1'b0, 1'b1, 1'b1};
        clear_inputs();
        #3;
        chk("rst_arready", 64'(o_arready), 64'(0));
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_rready", 64'(rready), 64'(0));
        chk("rst_rerr", 64'(rerr), 64'(0));
        chk("rst_ar_fields", 64'({arid, araddr, arlen}), 64'(0));
        tick(); tick();
        rst_n = 1'b1;

        // Unsolicited beat with nothing outstanding stalls.
        tick(); s_rvalid = 1'b1;
        #1 chk("unsol_rready", 64'(rready), 64'(0));
        chk("unsol_rvalid", 64'(o_rvalid), 64'(0));

        // Single request from a.
        tick(); s_rvalid = 1'b0; in_arvalid = 4'b0001; in_araddr[0] = 32'h100; in_arlen[0] = 8'd3;
        #1 chk("t1_a_arready", 64'(o_arready), 64'(4'b0001));
        tick(); in_arvalid = 4'b0;
        #1 chk("t1_arvalid", 64'(arvalid), 64'(1));
        chk("t1_araddr", 64'(araddr), 64'(32'h100));
        chk("t1_arlen", 64'(arlen), 64'(3));
        for (int k = 0; k < 4; k++) begin
            tick(); drive_beat(64'(8'hA0 + 8'(k)), k == 3);
            #1 chk("t1_rvalid", 64'(o_rvalid), 64'(4'b0001));
            chk("t1_rlast", 64'(o_rlast[0]), 64'(k == 3));
        end
        tick(); s_rvalid = 1'b0; s_rlast = 1'b0;

        // All four requesting: round-robin order, continuous arvalid.
        do_reset();
        tick(); in_arvalid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            #1 chk("t2_grant", 64'(o_arready), 64'(ord[k]));
            if (k > 0) begin
                chk("t2_arvalid", 64'(arvalid), 64'(1));
                chk("t2_arid", 64'(arid), 64'(ids[k-1]));
            end
            tick();
        end
        in_arvalid = 4'b0;
        #1 chk("t2_last_arid", 64'(arid), 64'(2));
        for (int k = 0; k < 6; k++) begin
            tick(); drive_beat(64'(k), 1'b1);
            #1 chk("t2_route", 64'(o_rvalid), 64'(ord[k]));
        end
        tick(); s_rvalid = 1'b0;

        // c (2 beats) then a (1 beat) routed in issue order.
        do_reset();
        tick(); in_arvalid = 4'b0100; in_arlen[2] = 8'd1;
        #1 chk("t3_c_grant", 64'(o_arready), 64'(4'b0100));
        tick(); in_arvalid = 4'b0001;
        #1 chk("t3_a_grant", 64'(o_arready), 64'(4'b0001));
        tick(); in_arvalid = 4'b0;
        for (int k = 0; k < 3; k++) begin
            drive_beat(64'(8'hC0 + 8'(k)), t3l[k]);
            #1 chk("t3_route", 64'(o_rvalid), 64'(t3v[k]));
            tick();
        end
        s_rvalid = 1'b0; s_rlast = 1'b0;

        // Fill the route FIFO, then retire and accept in the same cycle.
        do_reset();
        tick(); in_arvalid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            #1 chk("t4_fill", 64'(o_arready), 64'(4'b0001));
            tick();
        end
        #1 chk("t4_full_block", 64'(o_arready), 64'(0));
        tick(); drive_beat(64'h55, 1'b1);
        #1 chk("t4_pop_push", 64'(o_arready), 64'(4'b0001));
        tick(); s_rvalid = 1'b0;
        #1 chk("t4_full_again", 64'(o_arready), 64'(0));
        tick(); in_arvalid = 4'b0;
        for (int k = 0; k < 8; k++) begin
            drive_beat(64'(k), 1'b1);
            #1 chk("t4_drain", 64'(o_rvalid), 64'(4'b0001));
            tick();
        end
        s_rvalid = 1'b0;

        // Backpressure from the head master.
        do_reset();
        tick(); in_arvalid = 4'b0010; in_arlen[1] = 8'd1;
        tick(); in_arvalid = 4'b0; in_rready[1] = 1'b0; drive_beat(64'hBEEF, 1'b0);
        #1 chk("t5_stall_rready", 64'(rready), 64'(0));
        chk("t5_stall_rvalid", 64'(o_rvalid), 64'(4'b0010));
        tick();
        #1 chk("t5_hold_rready", 64'(rready), 64'(0));
        chk("t5_hold_data", 64'(o_rdata[1]), 64'(64'hBEEF));
        tick(); in_rready[1] = 1'b1;
        #1 chk("t5_release", 64'(rready), 64'(1));
        tick(); drive_beat(64'hCAFE, 1'b1);
        #1 chk("t5_second", 64'(rready), 64'(1));
        tick(); s_rvalid = 1'b0; s_rlast = 1'b0;

        // Slave AR stall: stage holds, arbiter waits.
        do_reset();
        tick(); s_arready = 1'b0; in_arvalid = 4'b0011;
        #1 chk("t6_first", 64'(o_arready), 64'(4'b0001));
        tick();
        #1 chk("t6_blocked", 64'(o_arready), 64'(0));
        chk("t6_hold_addr", 64'(araddr), 64'(32'h1000));
        tick(); s_arready = 1'b1;
        #1 chk("t6_b_grant", 64'(o_arready), 64'(4'b0010));
        tick(); in_arvalid = 4'b0;
        #1 chk("t6_b_arid", 64'(arid), 64'(2));
        for (int k = 0; k < 2; k++) begin
            tick(); drive_beat(64'(k), 1'b1);
        end
        tick(); s_rvalid = 1'b0;

        // len=2 burst ended early by the slave on beat 2.
        do_reset();
        tick(); in_arvalid = 4'b0001; in_arlen[0] = 8'd2;
        tick(); in_arvalid = 4'b0; drive_beat(64'h1, 1'b0);
        tick(); drive_beat(64'h2, 1'b1);
        tick(); s_rvalid = 1'b0; s_rlast = 1'b0;
`ifdef AXI_MERGER_LEN_CHECK_EN
        #1 chk("t7_rerr_set", 64'(rerr), 64'(1));
        tick(); tick();
        #1 chk("t7_rerr_sticky", 64'(rerr), 64'(1));
`else
        #1 chk("t7_rerr_off", 64'(rerr), 64'(0));
        chk("t7_popped", 64'(rready), 64'(0));
        tick(); tick();
`endif
        do_reset();
        #1 chk("t7_rerr_cleared", 64'(rerr), 64'(0));
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_4_merger.md
Name: axi_rd_4_merger

Overview:
- 4-to-1 AXI read merger: four read masters (a..d) share one downstream read slave port.
- Sits directly downstream of the per-region splitter outputs; one instance per region combines the matching splitter outputs toward a single memory or peripheral.
- AR is arbitrated round-robin. R beats are routed back by an in-order route FIFO of granted master indices.
- The slave must return bursts in AR order.

Parameters:
- EXTRAS, 8, width of the arextras sideband.
- IDWID, 4, AXI ID width.
- DWID, 64, read data width.
- RDEPTH, 8, route FIFO depth; max outstanding bursts; power of 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- {a,b,c,d}_arid  input  IDWID  per-master AR id.
- {a,b,c,d}_araddr  input  32  per-master AR address.
- {a,b,c,d}_arlen  input  8  per-master burst length minus 1.
- {a,b,c,d}_arextras  input  EXTRAS  per-master sideband.
- {a,b,c,d}_arburst  input  2  per-master burst type.
- {a,b,c,d}_arvalid  input  1  per-master AR valid.
- {a,b,c,d}_arready  output  1  per-master AR ready.
- {a,b,c,d}_rid  output  IDWID  per-master R id.
- {a,b,c,d}_rdata  output  DWID  per-master R data.
- {a,b,c,d}_rresp  output  2  per-master R response.
- {a,b,c,d}_rlast  output  1  per-master R last.
- {a,b,c,d}_rvalid  output  1  per-master R valid.
- {a,b,c,d}_rready  input  1  per-master R ready.
- arid, araddr, arlen, arextras, arburst, arvalid  output  (as above)  merged AR toward slave.
- arready  input  1  slave AR ready.
- rid, rdata, rresp, rlast, rvalid  input  (as above)  slave R.
- rready  output  1  R ready to slave.
- rerr  output  1  sticky burst-length error (see Optional Feature).

Behaviour:
- Clock and reset: single clock clk, rising edge. rst_n is asynchronous, active-low.
- Reset values: all x_arready=0, x_rvalid=0, arvalid=0, rready=0, rerr=0, AR register fields=0, RR pointer=a (index 0), route FIFO empty.

AR path:
- Registered output stage: a single entry holding {src[1:0], id, addr, len, extras, burst}.
- Stage loads when it is empty or is being drained (arvalid && arready) and the route FIFO is not full.
- Arbiter: round-robin over x_arvalid, searching from last_grant+1 in order a→b→c→d, wrapping d→a.
- Exactly one x_arready=1, for the winner, in the load cycle. All others are 0.
- AR latency: master handshake in cycle N → arvalid=1 in N+1. Back-to-back issue at 1/cycle when arready is held high.
- Once arvalid=1, the AR fields are stable until arready.
- The route FIFO is pushed with src on the master-side handshake, not the slave-side one.
- Route FIFO full (count==RDEPTH) → all x_arready=0; the AR register still drains normally.
- Single requester: granted every cycle, with no bubble.

R path:
- No buffering. head = route FIFO head src.
- When the FIFO is non-empty: {head}_rvalid=rvalid, rready={head}_rready. Other x_rvalid=0.
- rid/rdata/rresp/rlast fan out to all four masters; only the head's valid is asserted.
- Route FIFO empty → rready=0 and all x_rvalid=0. An unsolicited beat stalls and is never dropped.
- Pop on rvalid && rready && rlast.
- Push and pop in the same cycle: count unchanged. This is legal when full.

Reset mid-operation: everything clears immediately. Outstanding bursts are abandoned, and the slave must also be reset.

Optional Feature:
- Macro: AXI_MERGER_LEN_CHECK_EN.
- When defined:
  - The route FIFO also stores arlen; an 8-bit beat counter is added.
  - On each R beat the counter increments; it clears on pop.
  - The beat where count==len forces the master-side rlast=1 and pops, even if slave rlast=0.
  - Slave rlast=1 with count!=len, or slave rlast=0 at count==len, sets rerr=1. rerr is sticky until reset.
- When undefined: rerr is tied 0, no counter, and master-side rlast = slave rlast.

Test Plan:
- Reset then idle: all outputs 0. Release rst_n and set a_arvalid=1, araddr=0x100, len=3 → a_arready=1 in the next cycle, arvalid=1 with araddr=0x100 one cycle later.
- All four arvalid held, arready=1 → grant order a,b,c,d,a,b over 6 consecutive cycles, and arvalid stays high continuously.
- Issue c(len=1) then a(len=0). Slave returns 2 beats then 1 beat → c_rvalid on beats 1–2, then a_rvalid on beat 3. Other x_rvalid stay 0 throughout.
- RDEPTH=8 outstanding with no R returned → 9th request sees x_arready=0. One rlast pop plus a simultaneous new request → accepted, count stays 8.
- b_rready=0 while b is head and rvalid=1 → rready=0, and data is held until b_rready=1.
- With AXI_MERGER_LEN_CHECK_EN: len=2, slave rlast on beat 2 → rerr=1, which stays 1 until rst_n=0.
